// File: rtl/life_step_sequencer.sv
// rtl/life_step_sequencer.sv - one Game of Life generation per start, one cell per clock
// Uses a single shared neighbour counter; the new grid goes to a shadow buffer and is committed at once.
module bit_counter (
    input  logic [7:0] bits,
    output logic [3:0] count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, bits[i]};
        end
    end
endmodule

module life_step_sequencer #(
    parameter int N     = 8,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load_en,
    input  logic [N*N-1:0]   load_data,
    output logic [N*N-1:0]   cells,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] generation
);
    localparam int NN = N * N;
    localparam int IW = $clog2(NN);
    localparam int RW = $clog2(N);
    localparam logic [IW-1:0] LAST     = IW'(NN - 1);
    localparam logic [RW-1:0] COL_LAST = RW'(N - 1);

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   idx;
    logic [RW-1:0]   row, col;
    logic [NN-1:0]   next_buf;
    logic [8:0]      win;
    logic [7:0]      nbrs;
    logic [3:0]      count;
    logic            nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!load_en && start) state_nxt = SCAN;
            SCAN:    if (idx == LAST) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SCAN) || (state == COMMIT);
    end

    // 3x3 window around (row,col); cells outside the grid stay 0, no wrap-around.
    always_comb begin
        win = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if ((int'(row) + dr >= 0) && (int'(row) + dr < N) &&
                    (int'(col) + dc >= 0) && (int'(col) + dc < N))
                    win[4'((dr + 1) * 3 + dc + 1)] =
                        cells[IW'((int'(row) + dr) * N + int'(col) + dc)];
            end
        end
    end

    assign nbrs = {win[8:5], win[3:0]};

    bit_counter u_bit_counter (
        .bits  (nbrs),
        .count (count)
    );

    assign nxt = (count == 4'd3) | (cells[idx] & (count == 4'd2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells      <= '0;
            generation <= '0;
            done       <= 1'b0;
            idx        <= '0;
            row        <= '0;
            col        <= '0;
            next_buf   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_en) begin
                        cells      <= load_data;
                        generation <= '0;
                    end else if (start) begin
                        idx <= '0;
                        row <= '0;
                        col <= '0;
                    end
                end
                SCAN: begin
                    next_buf[idx] <= nxt;
                    if (idx != LAST) begin
                        idx <= idx + 1'b1;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    cells      <= next_buf;
                    generation <= generation + 1'b1;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_life_step_sequencer.sv
// tb/tb_life_step_sequencer.sv - scoreboard bench for life_step_sequencer (N=8, GEN_W=16 and GEN_W=2)
module tb_life_step_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        load_en = 1'b0;
    logic [63:0] load_data = '0;
    logic [63:0] cells, cells2;
    logic        busy, busy2, done, done2;
    logic [15:0] generation;
    logic [1:0]  gen2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int popped = 0;
    int mgen = 0;

    typedef struct {
        logic [63:0] cells;
        int          gen;
        int          e0;
    } exp_t;
    exp_t q[$];
    exp_t e;

    life_step_sequencer #(.N(8), .GEN_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_data(load_data),
        .cells(cells), .busy(busy), .done(done), .generation(generation)
    );

    life_step_sequencer #(.N(8), .GEN_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_data(load_data),
        .cells(cells2), .busy(busy2), .done(done2), .generation(gen2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] p(input int r, input int c);
        logic [63:0] one;
        one = 64'd1;
        return one << (r * 8 + c);
    endfunction

    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done actual=1 expected=0");
            end else begin
                e = q.pop_front();
                chk("step_cells", cells, e.cells);
                chk("step_gen", 64'(generation), 64'(e.gen));
                chk("step_gen_w2", 64'(gen2), 64'(e.gen % 4));
                chk("step_latency", 64'(cyc - e.e0), 64'd65);
            end
            popped++;
        end
    end

    task automatic load(input logic [63:0] g);
        @(posedge clk); #1;
        load_en = 1'b1;
        load_data = g;
        @(posedge clk); #1;
        load_en = 1'b0;
        mgen = 0;
        chk("load_cells", cells, g);
        chk("load_gen", 64'(generation), 64'd0);
    endtask

    task automatic step(input logic [63:0] expc, input bit inject);
        int want;
        want = popped + 1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mgen++;
        q.push_back('{cells: expc, gen: mgen, e0: cyc});
        chk("busy_after_start", 64'(busy), 64'd1);
        if (inject) begin
            repeat (10) @(posedge clk);
            #1;
            load_en = 1'b1;
            start = 1'b1;
            load_data = 64'hFFFF_0000_FFFF_0000;
            @(posedge clk); #1;
            load_en = 1'b0;
            start = 1'b0;
            chk("busy_ignores_pulses", 64'(busy), 64'd1);
        end
        for (int i = 0; i < 200 && popped < want; i++) @(posedge clk);
        if (popped < want) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=none expected=done");
        end
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
    endtask

    logic [63:0] blink_h, blink_v, block, edge_in, edge_out;

    initial begin
        blink_h  = p(3,2) | p(3,3) | p(3,4);
        blink_v  = p(2,3) | p(3,3) | p(4,3);
        block    = p(0,0) | p(0,1) | p(1,0) | p(1,1);
        edge_in  = p(0,7) | p(1,7) | p(2,7);
        edge_out = p(1,6) | p(1,7);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_cells", cells, 64'd0);
        chk("reset_gen", 64'(generation), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);

        load(blink_h);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_reset_cells", cells, 64'd0);
        chk("async_reset_busy", 64'(busy), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        load(blink_h);
        step(blink_v, 1'b0);
        step(blink_h, 1'b0);

        load(block);
        step(block, 1'b0);
        step(block, 1'b0);
        step(block, 1'b0);
        step(block, 1'b0);

        load(edge_in);
        step(edge_out, 1'b0);

        load(blink_h);
        step(blink_v, 1'b1);

        @(posedge clk); #1;
        load_en = 1'b1;
        start = 1'b1;
        load_data = block;
        @(posedge clk); #1;
        load_en = 1'b0;
        start = 1'b0;
        mgen = 0;
        chk("collide_busy", 64'(busy), 64'd0);
        chk("collide_cells", cells, block);
        chk("collide_gen", 64'(generation), 64'd0);
        repeat (3) @(posedge clk);
        #1 chk("collide_still_idle", 64'(busy), 64'd0);

        load(blink_h);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midscan_busy", 64'(busy), 64'd0);
        chk("midscan_cells", cells, 64'd0);
        chk("midscan_gen", 64'(generation), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (80) @(posedge clk);
        #1 chk("midscan_no_step", cells, 64'd0);

        load(blink_h);
        step(blink_v, 1'b0);

        repeat (5) @(posedge clk);
        #1 chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
